// File: rtl/ntt_twiddle_sched_if.sv
// Butterfly issue channel between the NTT twiddle scheduler and the butterfly unit.
// The scheduler drives the tuple and valid; the butterfly unit answers with ready.
interface ntt_twiddle_sched_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] tw_idx;
    logic [2:0] layer;
    logic       last;

    modport master (
        output issue_valid, addr_a, addr_b, tw_idx, layer, last,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, addr_a, addr_b, tw_idx, layer, last,
        output issue_ready
    );
endinterface

// File: rtl/ntt_twiddle_sched.sv
// ML-KEM NTT/INTT butterfly scheduler: walks 7 layers x 128 butterflies, issuing
// coefficient address pairs and zeta ROM indices, with a drain gap between layers.
module ntt_twiddle_sched #(
    parameter int unsigned LAYER_GAP = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        inverse,
    ntt_twiddle_sched_if.master         bus,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_l,     w_l_nxt;
    logic [6:0] r_c,     w_c_nxt;
    logic [3:0] r_g,     w_g_nxt;
    logic       r_m,     w_m_nxt;
    logic       r_done,  w_done_nxt;

    // NOTE: state is updated only with non-blocking assignments so every register
    // samples the same pre-edge values; reset is asynchronous and aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_l     <= '0;
            r_c     <= '0;
            r_g     <= '0;
            r_m     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_l     <= w_l_nxt;
            r_c     <= w_c_nxt;
            r_g     <= w_g_nxt;
            r_m     <= w_m_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // NOTE: every next-state signal gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_l_nxt     = r_l;
        w_c_nxt     = r_c;
        w_g_nxt     = r_g;
        w_m_nxt     = r_m;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped; one cycle later it is taken.
                if (start && !r_done) begin
                    w_state_nxt = S_RUN;
                    w_m_nxt     = inverse;
                    w_l_nxt     = '0;
                    w_c_nxt     = '0;
                end
            end
            S_RUN: begin
                if (bus.issue_ready) begin
                    w_c_nxt = r_c + 7'd1;
                    if (r_c == 7'd127) begin
                        if (r_l == 3'd6) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_l_nxt = r_l + 3'd1;
                            if (LAYER_GAP != 0) begin
                                w_state_nxt = S_GAP;
                                w_g_nxt     = '0;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_g == 4'(LAYER_GAP - 1)) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_g_nxt = r_g + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tuple decode: s = log2(len) is 7-l going forward and l+1 going inverse.
    logic       w_valid;
    logic [2:0] w_s;
    logic [3:0] w_s1;
    logic [7:0] w_len;
    logic [6:0] w_grp;
    logic [7:0] w_j;
    logic [7:0] w_addr_a;
    logic [7:0] w_addr_b;
    logic [6:0] w_tw;

    always_comb begin
        w_valid  = (r_state == S_RUN);
        w_s      = r_m ? (r_l + 3'd1) : (3'd7 - r_l);
        w_s1     = {1'b0, w_s} + 4'd1;
        w_len    = 8'd1 << w_s;
        w_grp    = r_c >> w_s;
        w_j      = {1'b0, r_c} & (w_len - 8'd1);
        w_addr_a = ({1'b0, w_grp} << w_s1) | w_j;
        w_addr_b = w_addr_a + w_len;
        // Inverse index (2 << (6-l)) - 1 - grp folds to (127 >> l) - grp.
        w_tw     = r_m ? ((7'h7F >> r_l) - w_grp) : ((7'd1 << r_l) + w_grp);
    end

    assign bus.issue_valid = w_valid;
    assign bus.addr_a      = w_valid ? w_addr_a : 8'd0;
    assign bus.addr_b      = w_valid ? w_addr_b : 8'd0;
    assign bus.tw_idx      = w_valid ? w_tw : 7'd0;
    assign bus.last        = w_valid && (r_l == 3'd6) && (r_c == 7'd127);
    assign busy            = (r_state != S_IDLE);
    assign bus.layer       = busy ? r_l : 3'd0;
    assign done            = r_done;

endmodule

// File: tb/tb_ntt_twiddle_sched.sv
// Randomized bench for ntt_twiddle_sched: expected tuples come from the textbook
// NTT/INTT loop nest, compared at every handshake of two DUTs (gap 4 and gap 0).
module tb_ntt_twiddle_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, inverse, ready, sel0;
    logic start4, start0, busy4, busy0, done4, done0;
    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    ntt_twiddle_sched_if if4();
    ntt_twiddle_sched_if if0();

    assign start4          = start & ~sel0;
    assign start0          = start & sel0;
    assign if4.issue_ready = ready;
    assign if0.issue_ready = ready;

    ntt_twiddle_sched #(.LAYER_GAP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .inverse(inverse),
        .bus(if4.master), .busy(busy4), .done(done4)
    );

    ntt_twiddle_sched #(.LAYER_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .inverse(inverse),
        .bus(if0.master), .busy(busy0), .done(done0)
    );

    logic       v, lst, bsy, dn;
    logic [7:0] a, b;
    logic [6:0] tw;
    logic [2:0] ly;

    assign v   = sel0 ? if0.issue_valid : if4.issue_valid;
    assign a   = sel0 ? if0.addr_a      : if4.addr_a;
    assign b   = sel0 ? if0.addr_b      : if4.addr_b;
    assign tw  = sel0 ? if0.tw_idx      : if4.tw_idx;
    assign ly  = sel0 ? if0.layer       : if4.layer;
    assign lst = sel0 ? if0.last        : if4.last;
    assign bsy = sel0 ? busy0           : busy4;
    assign dn  = sel0 ? done0           : done4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
        logic [2:0] ly;
        logic       last;
    } tup_t;

    tup_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: standard Cooley-Tukey / Gentleman-Sande loop nest over len, start, j.
    function automatic void build(input bit inv);
        tup_t t;
        int k;
        int lyr;
        int len;
        exp_q.delete();
        k   = inv ? 127 : 1;
        lyr = 0;
        len = inv ? 2 : 128;
        while (len >= 2 && len <= 128) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    t.a    = 8'(j);
                    t.b    = 8'(j + len);
                    t.tw   = 7'(k);
                    t.ly   = 3'(lyr);
                    t.last = 1'b0;
                    exp_q.push_back(t);
                end
                k = inv ? k - 1 : k + 1;
            end
            lyr++;
            len = inv ? len * 2 : len / 2;
        end
        exp_q[exp_q.size() - 1].last = 1'b1;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"}, v, 0);
        check({pfx, "_addr_a"}, a, 0);
        check({pfx, "_addr_b"}, b, 0);
        check({pfx, "_tw_idx"}, tw, 0);
        check({pfx, "_layer"}, ly, 0);
        check({pfx, "_last"}, lst, 0);
        check({pfx, "_busy"}, bsy, 0);
        check({pfx, "_done"}, dn, 0);
    endtask

    task automatic run(input bit use0, input bit inv, input int low_pct, input int abort_at);
        int   gap;
        int   hs;
        int   vlow;
        int   budget;
        int   fv;
        bit   stalled;
        tup_t t;
        tup_t held;
        gap     = use0 ? 0 : 4;
        hs      = 0;
        vlow    = 0;
        budget  = 0;
        stalled = 1'b0;
        build(inv);
        sel0 = use0;
        ready = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        inverse = inv;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", bsy, 1);
        check("valid_after_start", v, 1);
        fv = int'(cyc);
        while (exp_q.size() > 0 && budget < 6000) begin
            budget++;
            if (stalled) begin
                check("stall_valid", v, 1);
                check("stall_addr_a", a, held.a);
                check("stall_addr_b", b, held.b);
                check("stall_tw_idx", tw, held.tw);
            end
            stalled = 1'b0;
            inverse = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 19) == 0);
            if (v) begin
                ready = ($urandom_range(0, 99) >= low_pct);
                if (ready) begin
                    t = exp_q.pop_front();
                    check("addr_a", a, t.a);
                    check("addr_b", b, t.b);
                    check("tw_idx", tw, t.tw);
                    check("layer", ly, t.ly);
                    check("last", lst, t.last);
                    hs++;
                    if (hs == abort_at) begin
                        @(posedge clk);
                        #2 rst_n = 1'b0;
                        #1 check_all_zero("abort");
                        @(negedge clk);
                        rst_n = 1'b1;
                        start = 1'b0;
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            check("abort_no_done", dn, 0);
                            check("abort_idle", bsy, 0);
                        end
                        return;
                    end
                end else begin
                    stalled = 1'b1;
                    held.a  = a;
                    held.b  = b;
                    held.tw = tw;
                end
            end else begin
                ready = 1'($urandom_range(0, 1));
                vlow++;
                check("gap_busy", bsy, 1);
            end
            @(negedge clk);
        end
        check("timeout_left", exp_q.size(), 0);
        check("done_pulse", dn, 1);
        check("busy_end", bsy, 0);
        check("valid_end", v, 0);
        check("gap_cycles", vlow, 6 * gap);
        if (low_pct == 0) check("latency", int'(cyc) - fv, 896 + 6 * gap);
        // Start in the done cycle must be dropped.
        start   = 1'b1;
        inverse = ~inv;
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_drop", dn, 0);
        check("start_in_done_ignored", bsy, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        inverse = 1'b0;
        ready   = 1'b0;
        sel0    = 1'b0;
        #12;
        check_all_zero("reset4");
        sel0 = 1'b1;
        #1;
        check_all_zero("reset0");
        sel0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 0, -1);
        run(0, 1, 0, -1);
        run(0, 0, 40, -1);
        run(0, 1, 40, -1);
        run(1, 0, 0, -1);
        run(1, 1, 30, -1);
        run(0, 0, 30, 300);
        run(0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
